// File: rtl/cond_branch_resolver.sv
// -----------------------------------------------------------------------------
// cond_branch_resolver
//
// Purpose:
//   Holds the Z/N flags produced by the compare unit in Execute and resolves
//   conditional branches against them. A taken branch becomes a redirect
//   towards Fetch (valid/ready handshake). Once Fetch accepts it, a flush pulse
//   of fixed length squashes younger instructions. Saturating statistics
//   counters track resolved and taken branches.
//
// Ports:
//   clk           in   1        clock, all state updates on rising edge
//   rst_n         in   1        asynchronous active-low reset
//   flags_we      in   1        capture cmp_result MSB / cmp_zero into flags
//   cmp_result    in   DATA_W   A-B from compare unit (MSB is the N flag)
//   cmp_zero      in   1        zero flag from compare unit
//   br_valid      in   1        branch request valid
//   br_ready      out  1        branch can be accepted (IDLE only)
//   br_cond       in   3        branch condition code (see cond_e)
//   br_target     in   ADDR_W   redirect address if taken
//   redir_valid   out  1        redirect pending towards Fetch
//   redir_ready   in   1        Fetch accepts redirect
//   redir_target  out  ADDR_W   redirect address, stable while redir_valid
//   flush         out  1        squash younger instructions
//   flag_z        out  1        registered zero flag
//   flag_n        out  1        registered negative flag
//   taken_cnt     out  CNT_W    branches resolved taken (saturating)
//   resolved_cnt  out  CNT_W    branches resolved in total (saturating)
// -----------------------------------------------------------------------------
module cond_branch_resolver #(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 8,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flags_we,
  input  logic [DATA_W-1:0] cmp_result,
  input  logic              cmp_zero,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic              redir_valid,
  input  logic              redir_ready,
  output logic [ADDR_W-1:0] redir_target,
  output logic              flush,
  output logic              flag_z,
  output logic              flag_n,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  resolved_cnt
);

  // Flush counter only needs to hold FLUSH_CYC-1.
  localparam int              FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    C_ALWAYS = 3'd0,
    C_EQ     = 3'd1,
    C_NE     = 3'd2,
    C_LT     = 3'd3,
    C_GE     = 3'd4,
    C_LE     = 3'd5,
    C_GT     = 3'd6,
    C_NEVER  = 3'd7
  } cond_e;

  state_e              state_q, state_d;
  logic                flag_z_q, flag_z_d;
  logic                flag_n_q, flag_n_d;
  logic                redir_valid_q, redir_valid_d;
  logic [ADDR_W-1:0]   redir_target_q, redir_target_d;
  logic                flush_q, flush_d;
  logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0]    resolved_cnt_q, resolved_cnt_d;

  logic                eff_z;
  logic                eff_n;
  logic                cond_true;
  logic                br_accept;

  // A branch resolved in the same cycle as a flag update must see the new
  // flags, otherwise a compare-then-branch pair would use stale state.
  assign eff_z = flags_we ? cmp_zero               : flag_z_q;
  assign eff_n = flags_we ? cmp_result[DATA_W-1]   : flag_n_q;

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(br_cond))
      C_ALWAYS: cond_true = 1'b1;
      C_EQ:     cond_true = eff_z;
      C_NE:     cond_true = ~eff_z;
      C_LT:     cond_true = eff_n;
      C_GE:     cond_true = ~eff_n;
      C_LE:     cond_true = eff_z | eff_n;
      C_GT:     cond_true = ~eff_z & ~eff_n;
      C_NEVER:  cond_true = 1'b0;
      default:  cond_true = 1'b0;
    endcase
  end

  // br_ready is a pure decode of the state register so it rises as soon as
  // reset is released (state is already IDLE).
  assign br_ready  = (state_q == ST_IDLE);
  assign br_accept = br_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d        = state_q;
    flag_z_d       = flag_z_q;
    flag_n_d       = flag_n_q;
    redir_valid_d  = redir_valid_q;
    redir_target_d = redir_target_q;
    flush_d        = flush_q;
    flush_cnt_d    = flush_cnt_q;
    taken_cnt_d    = taken_cnt_q;
    resolved_cnt_d = resolved_cnt_q;

    // Flags are captured regardless of the branch state machine.
    if (flags_we) begin
      flag_z_d = cmp_zero;
      flag_n_d = cmp_result[DATA_W-1];
    end

    case (state_q)
      ST_IDLE: begin
        if (br_accept) begin
          if (resolved_cnt_q != {CNT_W{1'b1}}) begin
            resolved_cnt_d = resolved_cnt_q + CNT_W'(1);
          end
          if (cond_true) begin
            if (taken_cnt_q != {CNT_W{1'b1}}) begin
              taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
            redir_target_d = br_target;
            redir_valid_d  = 1'b1;
            state_d        = ST_REDIRECT;
          end
        end
      end

      ST_REDIRECT: begin
        // Waits for Fetch indefinitely; target is held untouched.
        if (redir_ready) begin
          redir_valid_d = 1'b0;
          flush_d       = 1'b1;
          flush_cnt_d   = FC_LOAD;
          state_d       = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        if (flush_cnt_q == '0) begin
          flush_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end

      default: begin
        state_d       = ST_IDLE;
        redir_valid_d = 1'b0;
        flush_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      flag_z_q       <= 1'b0;
      flag_n_q       <= 1'b0;
      redir_valid_q  <= 1'b0;
      redir_target_q <= '0;
      flush_q        <= 1'b0;
      flush_cnt_q    <= '0;
      taken_cnt_q    <= '0;
      resolved_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      flag_z_q       <= flag_z_d;
      flag_n_q       <= flag_n_d;
      redir_valid_q  <= redir_valid_d;
      redir_target_q <= redir_target_d;
      flush_q        <= flush_d;
      flush_cnt_q    <= flush_cnt_d;
      taken_cnt_q    <= taken_cnt_d;
      resolved_cnt_q <= resolved_cnt_d;
    end
  end

  assign redir_valid  = redir_valid_q;
  assign redir_target = redir_target_q;
  assign flush        = flush_q;
  assign flag_z       = flag_z_q;
  assign flag_n       = flag_n_q;
  assign taken_cnt    = taken_cnt_q;
  assign resolved_cnt = resolved_cnt_q;

endmodule

// File: tb/tb_cond_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_cond_branch_resolver
//
// Purpose:
//   Self-checking bench for cond_branch_resolver. Two instances share all
//   inputs: the default one (CNT_W=8) and a narrow-counter one (CNT_W=2) used
//   to observe saturation. Expected redirect targets are queued when a taken
//   branch is driven and popped when the redirect handshake is observed.
// -----------------------------------------------------------------------------
module tb_cond_branch_resolver;

  localparam int DATA_W    = 4;
  localparam int ADDR_W    = 8;
  localparam int FLUSH_CYC = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flags_we;
  logic [DATA_W-1:0] cmp_result;
  logic              cmp_zero;
  logic              br_valid;
  logic [2:0]        br_cond;
  logic [ADDR_W-1:0] br_target;
  logic              redir_ready;

  logic              br_ready, redir_valid, flush, flag_z, flag_n;
  logic [ADDR_W-1:0] redir_target;
  logic [7:0]        taken_cnt, resolved_cnt;

  logic              s_br_ready, s_redir_valid, s_flush, s_flag_z, s_flag_n;
  logic [ADDR_W-1:0] s_redir_target;
  logic [1:0]        s_taken_cnt, s_resolved_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_t;

  // Reference model state
  logic m_z, m_n;
  int   m_res, m_tak;

  always #5 clk = ~clk;

  cond_branch_resolver #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FLUSH_CYC(FLUSH_CYC), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flags_we(flags_we), .cmp_result(cmp_result),
    .cmp_zero(cmp_zero), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_target(br_target), .redir_valid(redir_valid),
    .redir_ready(redir_ready), .redir_target(redir_target), .flush(flush),
    .flag_z(flag_z), .flag_n(flag_n), .taken_cnt(taken_cnt),
    .resolved_cnt(resolved_cnt)
  );

  cond_branch_resolver #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FLUSH_CYC(FLUSH_CYC), .CNT_W(2)
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .flags_we(flags_we), .cmp_result(cmp_result),
    .cmp_zero(cmp_zero), .br_valid(br_valid), .br_ready(s_br_ready),
    .br_cond(br_cond), .br_target(br_target), .redir_valid(s_redir_valid),
    .redir_ready(redir_ready), .redir_target(s_redir_target), .flush(s_flush),
    .flag_z(s_flag_z), .flag_n(s_flag_n), .taken_cnt(s_taken_cnt),
    .resolved_cnt(s_resolved_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic eval(input logic [2:0] c, input logic z, input logic n);
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return z || n;
      3'd6: return !z && !n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted redirect must match the oldest queued target.
  always @(negedge clk) begin
    if (rst_n && redir_valid && redir_ready) begin
      if (exp_q.size() == 0) begin
        chk("redir_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t = exp_q.pop_front();
        chk("redir_target", 32'(redir_target), 32'(exp_t));
        $display("redirect accepted target=%02h", redir_target);
      end
    end
  end

  task automatic model_reset();
    m_z = 1'b0; m_n = 1'b0; m_res = 0; m_tak = 0;
    exp_q.delete();
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_resolved"},   32'(resolved_cnt),   32'(sat(m_res, 255)));
    chk({tag, "_taken"},      32'(taken_cnt),      32'(sat(m_tak, 255)));
    chk({tag, "_s_resolved"}, 32'(s_resolved_cnt), 32'(sat(m_res, 3)));
    chk({tag, "_s_taken"},    32'(s_taken_cnt),    32'(sat(m_tak, 3)));
  endtask

  // Assert reset in the middle of a cycle and check outputs clear at once.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_redir_valid", 32'(redir_valid), 32'd0);
    chk("rst_flush",       32'(flush),       32'd0);
    chk("rst_flag_z",      32'(flag_z),      32'd0);
    chk("rst_flag_n",      32'(flag_n),      32'd0);
    chk("rst_target",      32'(redir_target), 32'd0);
    check_counters("rst");
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_br_ready", 32'(br_ready), 32'd1);
    $display("reset applied and released");
  endtask

  task automatic set_flags(input logic cz, input logic [DATA_W-1:0] cres);
    flags_we = 1'b1; cmp_zero = cz; cmp_result = cres;
    tick();
    flags_we = 1'b0;
    m_z = cz; m_n = cres[DATA_W-1];
    chk("flag_z", 32'(flag_z), 32'(m_z));
    chk("flag_n", 32'(flag_n), 32'(m_n));
    $display("flags set z=%0b n=%0b", flag_z, flag_n);
  endtask

  // Issue one branch, optionally together with a flag update.
  task automatic issue(input logic [2:0] c, input logic [ADDR_W-1:0] tgt,
                       input logic we, input logic cz, input logic [DATA_W-1:0] cres);
    int   n;
    logic ez, en, tk;
    n = 0;
    while (!br_ready && n < 50) begin
      tick();
      n++;
    end
    if (!br_ready) chk("br_ready_timeout", 32'd0, 32'd1);
    ez = we ? cz : m_z;
    en = we ? cres[DATA_W-1] : m_n;
    tk = eval(c, ez, en);
    br_valid = 1'b1; br_cond = c; br_target = tgt;
    flags_we = we; cmp_zero = cz; cmp_result = cres;
    if (we) begin
      m_z = cz; m_n = cres[DATA_W-1];
    end
    m_res++;
    if (tk) begin
      m_tak++;
      exp_q.push_back(tgt);
    end
    tick();
    br_valid = 1'b0; flags_we = 1'b0;
    chk("br_redir_valid", 32'(redir_valid), 32'(tk));
    chk("br_ready_after", 32'(br_ready),    32'(!tk));
    check_counters("br");
    $display("branch cond=%0d target=%02h taken=%0b resolved=%0d taken_cnt=%0d",
             c, tgt, redir_valid, resolved_cnt, taken_cnt);
  endtask

  // Complete a pending redirect after 'delay' stall cycles and check flush.
  task automatic do_redirect(input int delay);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("hold_redir_valid", 32'(redir_valid), 32'd1);
      chk("hold_br_ready",    32'(br_ready),    32'd0);
      if (exp_q.size() != 0) chk("hold_target", 32'(redir_target), 32'(exp_q[0]));
    end
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    chk("flush_start",       32'(flush),       32'd1);
    chk("flush_redir_valid", 32'(redir_valid), 32'd0);
    chk("flush_br_ready",    32'(br_ready),    32'd0);
    for (int i = 1; i < FLUSH_CYC; i++) begin
      tick();
      chk("flush_hold",  32'(flush),    32'd1);
      chk("flush_ready", 32'(br_ready), 32'd0);
    end
    tick();
    chk("flush_end",  32'(flush),    32'd0);
    chk("idle_ready", 32'(br_ready), 32'd1);
    $display("redirect completed after %0d stall cycles, flush done", delay);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flags_we = 1'b0; cmp_result = '0; cmp_zero = 1'b0;
    br_valid = 1'b0; br_cond = '0; br_target = '0; redir_ready = 1'b0;
    model_reset();

    // 1: reset state, then async mid-cycle reset clears captured flags
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("init_br_ready", 32'(br_ready),    32'd1);
    chk("init_valid",    32'(redir_valid), 32'd0);
    chk("init_flush",    32'(flush),       32'd0);
    check_counters("init");
    tick();
    set_flags(1'b1, 4'h8);
    mid_reset();

    // 2: EQ after zero compare, redirect accepted after 3 stall cycles
    set_flags(1'b1, 4'h0);
    issue(3'd1, 8'h3C, 1'b0, 1'b0, 4'h0);
    do_redirect(3);

    // 3: forwarding of flags written in the same cycle
    set_flags(1'b1, 4'h0);
    issue(3'd3, 8'h5A, 1'b1, 1'b0, 4'hE);   // LT with forwarded N=1 -> taken
    do_redirect(0);
    set_flags(1'b1, 4'h0);
    issue(3'd1, 8'h77, 1'b1, 1'b0, 4'hE);   // EQ with forwarded Z=0 -> not taken
    chk("fwd_flag_z", 32'(flag_z), 32'd0);

    // 4: back-to-back not-taken NE with Z=1
    mid_reset();
    set_flags(1'b1, 4'h0);
    for (int i = 0; i < 4; i++) issue(3'd2, 8'(8'h10 + i), 1'b0, 1'b0, 4'h0);
    chk("b2b_resolved", 32'(resolved_cnt), 32'd4);
    chk("b2b_taken",    32'(taken_cnt),    32'd0);

    // Mixed conditions against N=0,Z=0 (GT/GE/LE/NEVER)
    set_flags(1'b0, 4'h3);
    issue(3'd6, 8'hA1, 1'b0, 1'b0, 4'h0);
    do_redirect(1);
    issue(3'd5, 8'hA2, 1'b0, 1'b0, 4'h0);
    issue(3'd7, 8'hA3, 1'b0, 1'b0, 4'h0);
    issue(3'd4, 8'hA4, 1'b0, 1'b0, 4'h0);
    do_redirect(2);

    // 5: counter saturation on the CNT_W=2 instance
    mid_reset();
    for (int i = 0; i < 5; i++) begin
      issue(3'd0, 8'(8'hC0 + i), 1'b0, 1'b0, 4'h0);
      do_redirect(0);
    end
    chk("sat_s_taken",    32'(s_taken_cnt),    32'd3);
    chk("sat_s_resolved", 32'(s_resolved_cnt), 32'd3);
    chk("sat_taken",      32'(taken_cnt),      32'd5);

    // 6: reset during FLUSH aborts, no further redirect
    issue(3'd0, 8'hEE, 1'b0, 1'b0, 4'h0);
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    chk("abort_flush_on", 32'(flush), 32'd1);
    mid_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_redir", 32'(redir_valid), 32'd0);
      chk("abort_no_flush", 32'(flush),       32'd0);
      chk("abort_ready",    32'(br_ready),    32'd1);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
